ramb16_s4_port_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing the 4-bit port B of a 16Kb S1_S4 dual-port block RAM between two requesters.

---
 rtl/ramb16_s4_port_arb_if.sv | 24 ++
 rtl/ramb16_s4_port_arb.sv | 138 +++++++++++++
 tb/tb_ramb16_s4_port_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ramb16_s4_port_arb_if.sv
// Requester-side bus of the RAMB16 port-B arbiter: two request channels and the BUSY flag.
interface ramb16_s4_port_arb_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 4
);
  logic              REQ0, REQ1;
  logic              WE0, WE1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] DI0, DI1;
  logic              GNT0, GNT1;
  logic [DATA_W-1:0] DO0, DO1;
  logic              VLD0, VLD1;
  logic              BUSY;

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, DI0, DI1,
    input  GNT0, GNT1, DO0, DO1, VLD0, VLD1, BUSY
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, DI0, DI1,
    output GNT0, GNT1, DO0, DO1, VLD0, VLD1, BUSY
  );
endinterface

// File: rtl/ramb16_s4_port_arb.sv
// Round-robin sharing of RAMB16_S1_S4 port B between two requesters, with read-return routing.
// Optional power-up clear engine enabled by defining RAMB_ARB_CLEAR_EN.
module ramb16_s4_port_arb #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 4
`ifdef RAMB_ARB_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  ramb16_s4_port_arb_if.slave req,
  output logic                ENB,
  output logic                WEB,
  output logic                SSRB,
  output logic [ADDR_W-1:0]   ADDRB,
  output logic [DATA_W-1:0]   DIB,
  input  logic [DATA_W-1:0]   DOB
);

  // Pipeline tag following an access through the RAM latency
  typedef struct packed {
    logic vld;
    logic id;
    logic rd;
  } tag_t;

  tag_t              s1_q, s2_q;
  logic              gnt0_q, gnt1_q;
  logic              vld0_q, vld1_q;
  logic [DATA_W-1:0] do0_q, do1_q;
  logic              last_q;
  logic              busy;
  logic              elig0_c, elig1_c;
  logic              win0_c, win1_c;

`ifdef RAMB_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
`else
  assign busy = 1'b0;
`endif

  // A request granted last cycle is consumed; ties go to the requester that did not win last
  always_comb begin
    elig0_c = req.REQ0 & ~gnt0_q & ~busy;
    elig1_c = req.REQ1 & ~gnt1_q & ~busy;
    win0_c  = elig0_c & (~elig1_c | last_q);
    win1_c  = elig1_c & (~elig0_c | ~last_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      do0_q  <= '0;
      do1_q  <= '0;
      ENB    <= 1'b0;
      WEB    <= 1'b0;
      ADDRB  <= '0;
      DIB    <= '0;
      last_q <= 1'b1;
      s1_q   <= '0;
      s2_q   <= '0;
`ifdef RAMB_ARB_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy      <= 1'b1;
`endif
    end else begin
      gnt0_q <= win0_c;
      gnt1_q <= win1_c;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      ENB    <= 1'b0;
      WEB    <= 1'b0;
      s1_q   <= '{vld: win0_c | win1_c, id: win1_c, rd: win1_c ? ~req.WE1 : ~req.WE0};
      s2_q   <= s1_q;

      // RAM output settled one edge ago: steer it to the issuing requester
      if (s2_q.vld && s2_q.rd) begin
        if (s2_q.id) begin
          do1_q  <= DOB;
          vld1_q <= 1'b1;
        end else begin
          do0_q  <= DOB;
          vld0_q <= 1'b1;
        end
      end

      if (win0_c) begin
        ENB    <= 1'b1;
        WEB    <= req.WE0;
        ADDRB  <= req.ADDR0;
        DIB    <= req.DI0;
        last_q <= 1'b0;
      end else if (win1_c) begin
        ENB    <= 1'b1;
        WEB    <= req.WE1;
        ADDRB  <= req.ADDR1;
        DIB    <= req.DI1;
        last_q <= 1'b1;
      end

`ifdef RAMB_ARB_CLEAR_EN
      // Clear sweep owns the port until the last address has been written
      case (state_q)
        ST_CLEAR: begin
          ENB       <= 1'b1;
          WEB       <= 1'b1;
          DIB       <= CLR_VAL;
          ADDRB     <= clr_cnt_q;
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) begin
            state_q <= ST_RUN;
            busy    <= 1'b0;
          end
        end
        default: state_q <= ST_RUN;
      endcase
`endif
    end
  end

  assign SSRB     = 1'b0;
  assign req.GNT0 = gnt0_q;
  assign req.GNT1 = gnt1_q;
  assign req.VLD0 = vld0_q;
  assign req.VLD1 = vld1_q;
  assign req.DO0  = do0_q;
  assign req.DO1  = do1_q;
  assign req.BUSY = busy;

endmodule

// File: tb/tb_ramb16_s4_port_arb.sv
// Scoreboard bench for ramb16_s4_port_arb: random requesters, behavioural RAM on port B,
// rule-level arbitration model and an ordered queue of expected read returns.
module tb_ramb16_s4_port_arb;

`ifdef RAMB_ARB_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb, web, ssrb;
  logic [11:0] addrb;
  logic [3:0]  dib, dob;
  logic        ram_fill;

  ramb16_s4_port_arb_if bus ();

  ramb16_s4_port_arb dut (
    .CLK  (clk),
    .RST  (rst),
    .req  (bus),
    .ENB  (enb),
    .WEB  (web),
    .SSRB (ssrb),
    .ADDRB(addrb),
    .DIB  (dib),
    .DOB  (dob)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] init_val(input int a);
    logic [11:0] av;
    av = 12'(a);
    return CLEAR ? (av[3:0] | 4'h8) : (av[3:0] ^ 4'h9);
  endfunction

  // Behavioural RAMB16 port B: one-cycle read, write-first
  logic [3:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= init_val(a);
    end else if (enb) begin
      if (web) begin
        mem[addrb] <= dib;
        dob        <= dib;
      end else begin
        dob <= mem[addrb];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    bit         id;
    logic [3:0] data;
    int         due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [3:0]  shadow [DEPTH];
  bit          shadow_init = 1'b0;
  bit          pg0, pg1, last1;
  bit          g0, g1, e0, e1, busy_now;
  int unsigned clr_left;
  int          cyc;
  logic [1:0]  exp_v;

  // Monitor: checks every edge's outputs against the model, then advances the model
  always @(posedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
      pg0      = 1'b0;
      pg1      = 1'b0;
      last1    = 1'b1;
      clr_left = CLEAR ? DEPTH : 0;
      cyc      = 0;
      if (CLEAR || !shadow_init) begin
        for (int a = 0; a < DEPTH; a++) shadow[a] = CLEAR ? 4'h0 : init_val(a);
        shadow_init = 1'b1;
      end
    end else begin
      cyc++;
      exp_v = 2'b00;
      if (sb.size() != 0 && sb[0].due == cyc) exp_v = sb[0].id ? 2'b10 : 2'b01;
      chk("vld", {bus.VLD1, bus.VLD0}, exp_v);
      if (exp_v != 2'b00) begin
        e = sb.pop_front();
        chk(e.id ? "rdata1" : "rdata0", e.id ? bus.DO1 : bus.DO0, e.data);
      end

      busy_now = (clr_left > 0);
      e0 = bus.REQ0 && !pg0 && !busy_now;
      e1 = bus.REQ1 && !pg1 && !busy_now;
      g0 = e0 && (!e1 || last1);
      g1 = e1 && (!e0 || !last1);
      chk("gnt", {bus.GNT1, bus.GNT0}, {g1, g0});

      if (busy_now) begin
        chk("clr_bus", {ssrb, enb, web, addrb, dib}, {3'b011, 12'(DEPTH - clr_left), 4'h0});
        clr_left--;
      end else if (g0 || g1) begin
        if (g0) chk("bus0", {ssrb, enb, web, addrb, dib}, {2'b01, bus.WE0, bus.ADDR0, bus.DI0});
        else    chk("bus1", {ssrb, enb, web, addrb, dib}, {2'b01, bus.WE1, bus.ADDR1, bus.DI1});
        if (g0 ? bus.WE0 : bus.WE1)
          shadow[g0 ? bus.ADDR0 : bus.ADDR1] = g0 ? bus.DI0 : bus.DI1;
        else
          sb.push_back('{id: g1, data: shadow[g0 ? bus.ADDR0 : bus.ADDR1], due: cyc + 2});
        last1 = g1;
      end else begin
        chk("idle_bus", {ssrb, enb, web}, 3'b000);
      end
      chk("busy", bus.BUSY, clr_left > 0);
      pg0 = g0;
      pg1 = g1;
    end
  end

  function automatic logic [11:0] rand_addr();
    return ($urandom_range(0, 4) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
  endfunction

  // Hold each request until granted, then issue a fresh random one or go idle
  task automatic rand_step();
    if (!bus.REQ0 || bus.GNT0) begin
      bus.REQ0  = ($urandom_range(0, 3) != 0);
      bus.WE0   = 1'($urandom_range(0, 1));
      bus.ADDR0 = rand_addr();
      bus.DI0   = 4'($urandom);
    end
    if (!bus.REQ1 || bus.GNT1) begin
      bus.REQ1  = ($urandom_range(0, 3) != 0);
      bus.WE1   = 1'($urandom_range(0, 1));
      bus.ADDR1 = rand_addr();
      bus.DI1   = 4'($urandom);
    end
  endtask

  task automatic wait_gnt(input bit id, input int limit);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      got = id ? bus.GNT1 : bus.GNT0;
    end
    chk(id ? "wait_gnt1" : "wait_gnt0", got, 1);
  endtask

  task automatic idle(input int n);
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {bus.GNT1, bus.GNT0}, 2'b00);
    chk({tag, "_vld"}, {bus.VLD1, bus.VLD0}, 2'b00);
    chk({tag, "_bus"}, {ssrb, enb, web, addrb, dib}, 19'h0);
    chk({tag, "_do"}, {bus.DO1, bus.DO0}, 8'h00);
    chk({tag, "_busy"}, bus.BUSY, CLEAR);
  endtask

  initial begin
    rst       = 1'b1;
    ram_fill  = 1'b1;
    bus.REQ0  = 1'b0; bus.REQ1  = 1'b0;
    bus.WE0   = 1'b0; bus.WE1   = 1'b0;
    bus.ADDR0 = '0;   bus.ADDR1 = '0;
    bus.DI0   = '0;   bus.DI1   = '0;
    repeat (2) @(negedge clk);
    ram_fill = 1'b0;
    check_reset_outputs("reset");

    // Requester 1 asks in the very first cycle after release
    bus.REQ1  = 1'b1;
    bus.ADDR1 = 12'h00A;
    rst       = 1'b0;
    wait_gnt(1'b1, 5000);
    idle(4);

    // Write 4'hA at 0x005 by requester 1, then read it back through requester 0
    bus.REQ1 = 1'b1; bus.WE1 = 1'b1; bus.ADDR1 = 12'h005; bus.DI1 = 4'hA;
    wait_gnt(1'b1, 8);
    bus.REQ1 = 1'b0;
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h005;
    wait_gnt(1'b0, 8);
    idle(4);

    // Both requesters holding reads: grants must alternate
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h005;
    bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.ADDR1 = 12'hFFF;
    repeat (8) @(negedge clk);
    idle(4);

    // Single requester held: at most one grant every other cycle
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h003;
    repeat (6) @(negedge clk);
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      rand_step();
      @(negedge clk);
    end
    idle(4);

    // Reset pulse one cycle after a read grant: outputs clear at once, no late VLD
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 12'h005;
    wait_gnt(1'b0, 8);
    bus.REQ0 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < (CLEAR ? 4400 : 300); i++) begin
      rand_step();
      @(negedge clk);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
